// File: rtl/aes_round_key_store_if.sv
// Key-capture and key-replay bus of the AES-128 round key store.
// The master drives the capture/read requests; the slave (the store)
// returns the replayed round key and status.
interface aes_round_key_store_if #(
    parameter int WORD_W = 32
);
    // capture side
    logic              load_in;
    logic              kv_in;
    logic [3:0]        kround_in;
    logic [WORD_W-1:0] key0_in;
    logic [WORD_W-1:0] key1_in;
    logic [WORD_W-1:0] key2_in;
    logic [WORD_W-1:0] key3_in;
    // read side
    logic              rd_dir_in;
    logic              rd_restart_in;
    logic              rd_en_in;
    logic [WORD_W-1:0] key0_out;
    logic [WORD_W-1:0] key1_out;
    logic [WORD_W-1:0] key2_out;
    logic [WORD_W-1:0] key3_out;
    logic [3:0]        round_out;
    logic              key_valid_out;
    logic              last_out;
    // status
    logic              ready_out;
    logic              err_out;
    logic [1:0]        state_out;

    modport master (
        output load_in, kv_in, kround_in, key0_in, key1_in, key2_in, key3_in,
        output rd_dir_in, rd_restart_in, rd_en_in,
        input  key0_out, key1_out, key2_out, key3_out, round_out,
        input  key_valid_out, last_out, ready_out, err_out, state_out
    );

    modport slave (
        input  load_in, kv_in, kround_in, key0_in, key1_in, key2_in, key3_in,
        input  rd_dir_in, rd_restart_in, rd_en_in,
        output key0_out, key1_out, key2_out, key3_out, round_out,
        output key_valid_out, last_out, ready_out, err_out, state_out
    );
endinterface

// File: rtl/aes_round_key_store.sv
// AES-128 round key store: captures NUM_ROUNDS+1 round keys from the key
// expansion stage in any order, then replays them forward (encrypt) or
// reverse (decrypt) with one-cycle read latency, as often as needed.
module aes_round_key_store #(
    parameter int NUM_ROUNDS = 10,
    parameter int WORD_W     = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    aes_round_key_store_if.slave bus
);
    localparam int         DEPTH    = NUM_ROUNDS + 1;
    localparam int         KEY_W    = 4 * WORD_W;
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FILL   = 2'b01,
        S_READY  = 2'b10,
        S_STREAM = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEPTH-1:0] r_mask;
    logic [3:0]       r_ptr;
    logic             r_dir;
    logic [KEY_W-1:0] r_mem [0:DEPTH-1];
    logic [KEY_W-1:0] r_key_out;
    logic [3:0]       r_round;
    logic             r_kv;
    logic             r_last;
    logic             r_ready;
    logic             r_err;

    logic [KEY_W-1:0] w_key_in;
    logic             w_idx_ok;
    logic             w_mask_full;
    logic             w_rd_ok;
    logic             w_wr_en;
    logic [DEPTH-1:0] w_wr_bit;
    logic             w_restart;
    logic             w_rd_acc;
    logic             w_dir_eff;
    logic [3:0]       w_ptr_eff;
    logic             w_rd_last;
    logic             w_err_set;
    logic [3:0]       w_ptr_nxt;
    logic             w_dir_nxt;

    assign w_key_in    = {bus.key0_in, bus.key1_in, bus.key2_in, bus.key3_in};
    assign w_idx_ok    = (bus.kround_in <= LAST_IDX);
    assign w_mask_full = &r_mask;
    assign w_rd_ok     = (r_state == S_READY) || (r_state == S_STREAM);

    // load_in opens a fresh capture window in the same cycle, so a round key
    // arriving alongside it is stored after the clear.
    assign w_wr_en  = bus.kv_in && w_idx_ok && (bus.load_in || r_state == S_FILL);
    assign w_wr_bit = w_wr_en ? (DEPTH'(1) << bus.kround_in) : '0;

    // load_in overrides any read or restart in the same cycle.
    assign w_restart = !bus.load_in && bus.rd_restart_in && w_rd_ok;
    assign w_rd_acc  = !bus.load_in && bus.rd_en_in && w_rd_ok;

    // A restart takes effect before a coincident read, so the read returns
    // the start of the newly selected sequence.
    assign w_dir_eff = w_restart ? bus.rd_dir_in : r_dir;
    assign w_ptr_eff = w_restart ? (bus.rd_dir_in ? LAST_IDX : 4'd0) : r_ptr;
    assign w_rd_last = w_dir_eff ? (w_ptr_eff == 4'd0) : (w_ptr_eff == LAST_IDX);

    // Any key not stored (bad index or wrong state) and any read outside
    // READY/STREAM is a protocol error.
    assign w_err_set = (bus.kv_in && !w_wr_en) ||
                       (!bus.load_in && bus.rd_en_in && !w_rd_ok);

    // Next-state logic for the capture/replay sequencer.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.load_in) begin
            w_state_nxt = S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_mask_full) w_state_nxt = S_READY;
                end
                S_READY, S_STREAM: begin
                    if (w_restart) w_state_nxt = S_READY;
                    if (w_rd_acc)  w_state_nxt = w_rd_last ? S_READY : S_STREAM;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State register; ready_out is registered alongside the state it mirrors.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_READY) || (w_state_nxt == S_STREAM);
        end
    end

    // Read pointer stepping; the final key wraps back to the sequence start.
    always_comb begin
        w_ptr_nxt = w_ptr_eff;
        w_dir_nxt = w_dir_eff;
        if (bus.load_in) begin
            w_ptr_nxt = 4'd0;
            w_dir_nxt = 1'b0;
        end else if (w_rd_acc) begin
            if (w_rd_last)      w_ptr_nxt = w_dir_eff ? LAST_IDX : 4'd0;
            else if (w_dir_eff) w_ptr_nxt = w_ptr_eff - 4'd1;
            else                w_ptr_nxt = w_ptr_eff + 4'd1;
        end
    end

    // Read pointer, direction, valid mask and sticky error flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ptr  <= 4'd0;
            r_dir  <= 1'b0;
            r_mask <= '0;
            r_err  <= 1'b0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_dir  <= w_dir_nxt;
            r_mask <= (bus.load_in ? '0 : r_mask) | w_wr_bit;
            r_err  <= (bus.load_in ? 1'b0 : r_err) | w_err_set;
        end
    end

    // Key storage; contents are meaningless until their mask bit is set.
    always_ff @(posedge CLK) begin
        if (w_wr_en) r_mem[bus.kround_in] <= w_key_in;
    end

    // Registered read port: key and round hold between accepted reads.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_key_out <= '0;
            r_round   <= 4'd0;
            r_kv      <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_kv   <= w_rd_acc;
            r_last <= w_rd_acc && w_rd_last;
            if (w_rd_acc) begin
                r_key_out <= r_mem[w_ptr_eff];
                r_round   <= w_ptr_eff;
            end
        end
    end

    assign bus.key0_out      = r_key_out[4*WORD_W-1 -: WORD_W];
    assign bus.key1_out      = r_key_out[3*WORD_W-1 -: WORD_W];
    assign bus.key2_out      = r_key_out[2*WORD_W-1 -: WORD_W];
    assign bus.key3_out      = r_key_out[WORD_W-1   -: WORD_W];
    assign bus.round_out     = r_round;
    assign bus.key_valid_out = r_kv;
    assign bus.last_out      = r_last;
    assign bus.ready_out     = r_ready;
    assign bus.err_out       = r_err;
    assign bus.state_out     = r_state;
endmodule

// File: tb/tb_aes_round_key_store.sv
// Bench for aes_round_key_store: directed fill/stream tables and corner
// sequences, then randomized traffic against a sequence-level model.
module tb_aes_round_key_store;
    localparam int NR = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_key_store_if #(.WORD_W(32)) bus ();
    aes_round_key_store #(.NUM_ROUNDS(NR), .WORD_W(32)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] kt [0:NR];

    typedef struct {
        logic       restart;
        logic       dir;
        logic       rd;
        logic       exp_kv;
        logic [3:0] exp_round;
        logic       exp_last;
        logic [1:0] exp_state;
    } vec_t;
    vec_t tbl[$];

    // reference model state
    logic [127:0] m_mem [0:NR];
    bit           m_mask [0:NR];
    int           m_ph, m_pos, m_round;
    bit           m_dir, m_kv, m_last, m_err;
    logic [127:0] m_key;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.load_in = 0; bus.kv_in = 0; bus.kround_in = 0;
        bus.key0_in = 0; bus.key1_in = 0; bus.key2_in = 0; bus.key3_in = 0;
        bus.rd_dir_in = 0; bus.rd_restart_in = 0; bus.rd_en_in = 0;
    endtask

    task automatic put_key(input int r, input logic [127:0] k);
        bus.kv_in = 1; bus.kround_in = 4'(r);
        {bus.key0_in, bus.key1_in, bus.key2_in, bus.key3_in} = k;
    endtask

    function automatic logic [127:0] out_key();
        return {bus.key0_out, bus.key1_out, bus.key2_out, bus.key3_out};
    endfunction

    function automatic vec_t mk(logic rs, logic d, logic rd, logic kv, int rnd, logic l, logic [1:0] st);
        vec_t v;
        v.restart = rs; v.dir = d; v.rd = rd; v.exp_kv = kv;
        v.exp_round = 4'(rnd); v.exp_last = l; v.exp_state = st;
        return v;
    endfunction

    // Model: keys addressed by round, replay tracked as a position within the
    // selected sequence (0..NR), round derived from direction.
    task automatic model_reset();
        for (int i = 0; i <= NR; i++) m_mask[i] = 0;
        m_ph = 0; m_pos = 0; m_dir = 0; m_round = 0;
        m_kv = 0; m_last = 0; m_err = 0; m_key = '0;
    endtask

    task automatic model_step();
        int ph0;
        int kr;
        bit full;
        logic [127:0] kin;
        ph0  = m_ph;
        kr   = int'(bus.kround_in);
        kin  = {bus.key0_in, bus.key1_in, bus.key2_in, bus.key3_in};
        full = 1;
        for (int i = 0; i <= NR; i++) if (!m_mask[i]) full = 0;
        m_kv = 0; m_last = 0;
        if (bus.load_in) begin
            for (int i = 0; i <= NR; i++) m_mask[i] = 0;
            m_pos = 0; m_dir = 0; m_err = 0; m_ph = 1;
            if (bus.kv_in) begin
                if (kr <= NR) begin m_mem[kr] = kin; m_mask[kr] = 1; end
                else m_err = 1;
            end
        end else begin
            if (bus.kv_in) begin
                if (ph0 == 1 && kr <= NR) begin m_mem[kr] = kin; m_mask[kr] = 1; end
                else m_err = 1;
            end
            if (ph0 == 1 && full) m_ph = 2;
            if (ph0 >= 2) begin
                if (bus.rd_restart_in) begin m_dir = bus.rd_dir_in; m_pos = 0; m_ph = 2; end
                if (bus.rd_en_in) begin
                    m_round = m_dir ? NR - m_pos : m_pos;
                    m_key   = m_mem[m_round];
                    m_kv    = 1;
                    m_last  = (m_pos == NR);
                    m_pos   = m_last ? 0 : m_pos + 1;
                    m_ph    = m_last ? 2 : 3;
                end
            end else if (bus.rd_en_in) begin
                m_err = 1;
            end
        end
    endtask

    initial begin
        kt[0]  = 128'h54686174_73206d79_204b756e_67204675;
        kt[1]  = 128'he232fcf1_91129188_b159e4e6_d679a293;
        kt[2]  = 128'h56082007_c71ab18f_76435569_a03af7fa;
        kt[3]  = 128'hd2600de7_157abc68_6339e901_c3031efb;
        kt[4]  = 128'ha11202c9_b468bea1_d75157a0_1452495b;
        kt[5]  = 128'hb1293b33_05418592_d210d232_c6429b69;
        kt[6]  = 128'hbd3dc287_b87c4715_6a6c9527_ac2e0e4e;
        kt[7]  = 128'hcc96ed16_74eaaa03_1e863f24_b2a8316a;
        kt[8]  = 128'h8e51ef21_fabb4522_e43d7a06_56954b6c;
        kt[9]  = 128'hbfe2bf90_4559fab2_a16480b4_f7f1cbd8;
        kt[10] = 128'h28fddef8_6da4244a_ccc0a4fe_3b316f26;

        // stream table: forward, reverse (restart with first read), wrap, hold, restart
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2'b10));
        for (int i = 0; i <= NR; i++)
            tbl.push_back(mk(0, 0, 1, 1, i, i == NR, (i == NR) ? 2'b10 : 2'b11));
        for (int i = 0; i <= NR; i++)
            tbl.push_back(mk(i == 0, 1, 1, 1, NR - i, i == NR, (i == NR) ? 2'b10 : 2'b11));
        tbl.push_back(mk(0, 1, 1, 1, NR, 0, 2'b11));
        tbl.push_back(mk(0, 1, 0, 0, NR, 0, 2'b11));
        tbl.push_back(mk(1, 0, 0, 0, NR, 0, 2'b10));

        // reset state
        idle_in();
        step(); step();
        check("rst_state", 160'(bus.state_out), 160'(0));
        check("rst_ready", 160'(bus.ready_out), 160'(0));
        check("rst_err",   160'(bus.err_out),   160'(0));
        check("rst_kv",    160'(bus.key_valid_out), 160'(0));
        check("rst_last",  160'(bus.last_out),  160'(0));
        check("rst_round", 160'(bus.round_out), 160'(0));
        check("rst_key",   160'(out_key()),     160'(0));
        rst_n = 1;
        step();

        // in-order fill
        bus.load_in = 1; step(); bus.load_in = 0;
        check("load_state", 160'(bus.state_out), 160'(2'b01));
        for (int r = 0; r <= NR; r++) begin
            put_key(r, kt[r]); step();
            check("fill_state", 160'({bus.state_out, bus.ready_out}), 160'({2'b01, 1'b0}));
        end
        idle_in(); step();
        check("fill_done", 160'({bus.state_out, bus.ready_out, bus.err_out}), 160'({2'b10, 1'b1, 1'b0}));

        // table-driven streaming
        for (int i = 0; i < tbl.size(); i++) begin
            bus.rd_restart_in = tbl[i].restart; bus.rd_dir_in = tbl[i].dir; bus.rd_en_in = tbl[i].rd;
            step();
            check($sformatf("tbl%0d_ctl", i), 160'({bus.key_valid_out, bus.last_out, bus.state_out}),
                  160'({tbl[i].exp_kv, tbl[i].exp_last, tbl[i].exp_state}));
            if (i > 0)
                check($sformatf("tbl%0d_data", i), 160'({bus.round_out, out_key()}),
                      160'({tbl[i].exp_round, kt[tbl[i].exp_round]}));
        end
        idle_in();

        // out-of-order fill, read during fill, reload with key, illegal index
        bus.load_in = 1; step(); bus.load_in = 0;
        for (int r = NR; r >= 6; r--) begin put_key(r, kt[r]); step(); end
        idle_in(); bus.rd_en_in = 1; step(); bus.rd_en_in = 0;
        check("fill_rd", 160'({bus.key_valid_out, bus.err_out, bus.state_out}), 160'({1'b0, 1'b1, 2'b01}));
        bus.load_in = 1; put_key(NR, kt[NR]); step(); bus.load_in = 0;
        check("reload_clr", 160'({bus.err_out, bus.state_out}), 160'({1'b0, 2'b01}));
        for (int r = NR - 1; r >= 0; r--) begin put_key(r, kt[r]); step(); end
        put_key(11, 128'hdeadbeef_deadbeef_deadbeef_deadbeef); step(); idle_in();
        check("bad_idx", 160'({bus.err_out, bus.state_out, bus.ready_out}), 160'({1'b1, 2'b10, 1'b1}));
        for (int i = 0; i <= NR; i++) begin
            bus.rd_restart_in = (i == 0); bus.rd_dir_in = 0; bus.rd_en_in = 1;
            step();
            check($sformatf("ooo_rd%0d", i), 160'({bus.key_valid_out, bus.last_out, bus.round_out, out_key()}),
                  160'({1'b1, i == NR, 4'(i), kt[i]}));
        end
        idle_in();

        // reload while streaming, with round 0 in the same cycle
        bus.rd_restart_in = 1; bus.rd_en_in = 1; step();
        bus.rd_restart_in = 0; step();
        check("pre_reload", 160'({bus.state_out, bus.err_out}), 160'({2'b11, 1'b1}));
        bus.load_in = 1; put_key(0, kt[0]); step(); idle_in();
        check("reload_stream", 160'({bus.state_out, bus.ready_out, bus.err_out, bus.key_valid_out}),
              160'({2'b01, 1'b0, 1'b0, 1'b0}));
        for (int r = 1; r < NR; r++) begin put_key(r, kt[r]); step(); end
        idle_in(); step();
        check("mask_bit0_only", 160'(bus.state_out), 160'(2'b01));
        put_key(NR, kt[NR]); step(); idle_in(); step();
        check("reload_ready", 160'({bus.state_out, bus.ready_out}), 160'({2'b10, 1'b1}));

        // async reset mid-fill
        bus.load_in = 1; step(); bus.load_in = 0;
        for (int r = 0; r < 5; r++) begin put_key(r, kt[r]); step(); end
        put_key(12, '1); step(); idle_in();
        #3 rst_n = 0;
        #1;
        check("arst_outs", 160'({bus.state_out, bus.ready_out, bus.err_out, bus.key_valid_out,
                                 bus.last_out, bus.round_out, out_key()}), 160'(0));
        #2 rst_n = 1;
        bus.rd_en_in = 1; step(); step(); bus.rd_en_in = 0;
        check("arst_idle_rd", 160'({bus.state_out, bus.key_valid_out, bus.err_out}), 160'({2'b00, 1'b0, 1'b1}));

        // randomized traffic against the model
        rst_n = 0; idle_in(); step(); rst_n = 1; model_reset(); step();
        for (int c = 0; c < 1500; c++) begin
            idle_in();
            bus.load_in = ($urandom_range(0, 79) == 0);
            bus.kv_in = (m_ph == 1) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 29) == 0);
            bus.kround_in = ($urandom_range(0, 19) == 0) ? 4'(15) : 4'($urandom_range(0, 11));
            bus.key0_in = $urandom; bus.key1_in = $urandom; bus.key2_in = $urandom; bus.key3_in = $urandom;
            bus.rd_en_in = ($urandom_range(0, 1) == 1);
            bus.rd_restart_in = ($urandom_range(0, 7) == 0);
            bus.rd_dir_in = 1'($urandom_range(0, 1));
            model_step();
            step();
            check($sformatf("rand%0d", c),
                  160'({bus.state_out, bus.ready_out, bus.err_out, bus.key_valid_out, bus.last_out,
                        bus.round_out, out_key()}),
                  160'({2'(m_ph), m_ph >= 2, m_err, m_kv, m_last, 4'(m_round), m_key}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
